apb_requester: RTL and testbench

Single-outstanding APB initiator that turns a valid/ready command interface into APB SETUP/ACCESS transfers and returns the completion on a valid/ready response interface. It drives the APB slaves in this design, including the 32-word APB RAM, from test sequencers or internal control logic. An optional, compile-time wait-state timeout terminates transfers to a hung slave.

---
 rtl/apb_requester_if.sv | 48 ++++
 rtl/apb_requester.sv | 165 ++++++++++++++++
 tb/tb_apb_requester.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_if.sv
// ============================================================================
// Module   : apb_requester_if
// Brief    : Command, response and APB bus bundle for apb_requester.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_requester_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

`default_nettype wire

// File: rtl/apb_requester.sv
// ============================================================================
// Module   : apb_requester
// Brief    : Single-outstanding APB initiator; valid/ready command in,
//            valid/ready response out. Define APB_REQUESTER_TIMEOUT_EN to
//            enable the ACCESS wait-state timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_requester #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            pclk,
  input  logic            preset,
  apb_requester_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_done;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("apb_requester: TIMEOUT must be at least 1");
  end

`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam int                 c_cnt_w      = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_wait_limit = c_cnt_w'(TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_rsp_timeout;
  logic               w_timeout;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_done        = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.psel      = 1'b0;
    bus.penable   = 1'b0;
    bus.rsp_valid = 1'b0;
`ifdef APB_REQUESTER_TIMEOUT_EN
    w_timeout     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = !preset;
        if (bus.cmd_valid && !preset) begin
          w_accept     = 1'b1;
          w_state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        bus.psel     = 1'b1;
        w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        // A ready slave wins over a timeout landing in the same cycle.
        if (bus.pready) begin
          w_done       = 1'b1;
          w_state_next = S_RESP;
        end
`ifdef APB_REQUESTER_TIMEOUT_EN
        else if (r_wait_cnt == c_wait_limit) begin
          w_timeout    = 1'b1;
          w_state_next = S_RESP;
        end
`endif
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pwrite <= bus.cmd_write;
        r_paddr  <= bus.cmd_addr;
        r_pwdata <= bus.cmd_wdata;
      end
      if (w_done) begin
        r_rsp_err   <= bus.pslverr;
        r_rsp_rdata <= (!r_pwrite && !bus.pslverr) ? bus.prdata : '0;
      end
`ifdef APB_REQUESTER_TIMEOUT_EN
      if (w_timeout) begin
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
      end
`endif
    end
  end

`ifdef APB_REQUESTER_TIMEOUT_EN
  // Counts ACCESS cycles without pready; saturates so it can never wrap.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_wait_cnt    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (r_state == S_SETUP) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_ACCESS && !bus.pready && r_wait_cnt != '1) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_done) begin
        r_rsp_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_timeout <= 1'b1;
      end
    end
  end

  assign bus.rsp_timeout = r_rsp_timeout;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_requester.sv
// ============================================================================
// Module   : tb_apb_requester
// Brief    : Self-checking bench for apb_requester against a transfer-level
//            timing model; honours APB_REQUESTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_apb_requester;
  localparam int TIMEOUT = 4;

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          slverr;
    logic [31:0] prdata;
    int          rdy;
  } plan_t;

  logic pclk   = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  apb_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  plan_t plans [128];
  int    n_plans    = 0;
  bit    rand_valid = 1'b0;

  // Transfer-level model: outputs follow from accept edge, ACCESS length and handshake.
  int          cyc = 0, t_acc = 0, ret_edge = 0, gap = 0, acc_count = 0, len = 1;
  bit          busy = 1'b0;
  int          cur_wait = 0, cur_rdy = 0;
  bit          cur_slverr = 1'b0;
  logic [31:0] cur_prdata = '0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  bit          m_write = 1'b0;
  logic [31:0] e_rdata = '0;
  bit          e_err = 1'b0, e_to = 1'b0;

  int          m_psel = 0, m_pen = 0, m_rv = 0, m_rv_k = 0, prev_acc = 0;
  logic [31:0] cap_pwdata = '0, cap_rdata = '0;
  bit          cap_err = 1'b0, cap_to = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic add(input bit w, input logic [31:0] a, input logic [31:0] d, input int waits,
                     input bit err, input logic [31:0] rd, input int rdy);
    plans[n_plans] = '{w, a, d, waits, err, rd, rdy};
    n_plans++;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (acc_count != n_plans || busy) begin
      @(negedge pclk);
      n++;
      if (n > maxc) begin
        checks++;
        failures++;
        $display("FAIL wait_idle: transfers not retired after %0d cycles", maxc);
        finish_tb();
      end
    end
    @(negedge pclk);
  endtask

  always @(posedge pclk or posedge preset) begin
    int    e, k;
    plan_t p;
    if (preset) begin
      busy    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_write = 1'b0;
    end else begin
      e = cyc + 1;
      k = e - t_acc;
      if (busy) begin
        if (k >= len + 2 && bus.rsp_ready) begin
          busy     = 1'b0;
          ret_edge = e;
        end
      end else if (bus.cmd_valid) begin
        p          = plans[acc_count];
        busy       = 1'b1;
        gap        = e - ret_edge;
        t_acc      = e;
        acc_count++;
        m_addr     = p.addr;
        m_wdata    = p.wdata;
        m_write    = p.write;
        cur_wait   = p.waits;
        cur_rdy    = p.rdy;
        cur_slverr = p.slverr;
        cur_prdata = p.prdata;
        len        = p.waits + 1;
        e_err      = p.slverr;
        e_to       = 1'b0;
        e_rdata    = (p.write || p.slverr) ? 32'h0 : p.prdata;
`ifdef APB_REQUESTER_TIMEOUT_EN
        if (p.waits >= TIMEOUT) begin
          len     = TIMEOUT;
          e_err   = 1'b1;
          e_to    = 1'b1;
          e_rdata = 32'h0;
        end
`endif
      end
      cyc = e;
    end
  end

  // Command source, APB slave and response consumer.
  always @(negedge pclk) begin
    int k;
    k = cyc + 1 - t_acc;
    if (acc_count < n_plans && (!rand_valid || $urandom_range(0, 1) == 1)) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = plans[acc_count].write;
      bus.cmd_addr  = plans[acc_count].addr;
      bus.cmd_wdata = plans[acc_count].wdata;
    end else begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom_range(0, 1));
      bus.cmd_addr  = $urandom;
      bus.cmd_wdata = $urandom;
    end
    if (busy && cur_wait < len && k == cur_wait + 2) begin
      bus.pready  = 1'b1;
      bus.prdata  = cur_prdata;
      bus.pslverr = cur_slverr;
    end else begin
      bus.pready  = 1'b0;
      bus.prdata  = $urandom;
      bus.pslverr = 1'($urandom_range(0, 1));
    end
    if (busy && k >= len + 2) bus.rsp_ready = (k - len - 2 >= cur_rdy);
    else                      bus.rsp_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge pclk) begin
    int k;
    bit ep, ee, ev, er;
    k  = cyc + 1 - t_acc;
    ep = busy && k >= 1 && k <= len + 1;
    ee = busy && k >= 2 && k <= len + 1;
    ev = busy && k >= len + 2;
    er = !busy && !preset;
    chk("psel", bus.psel, ep);
    chk("penable", bus.penable, ee);
    chk("rsp_valid", bus.rsp_valid, ev);
    chk("cmd_ready", bus.cmd_ready, er);
    chk("paddr", bus.paddr, m_addr);
    chk("pwrite", bus.pwrite, m_write);
    chk("pwdata", bus.pwdata, m_wdata);
    if (ev || preset) begin
      chk("rsp_rdata", bus.rsp_rdata, ev ? e_rdata : 32'h0);
      chk("rsp_err", bus.rsp_err, ev ? e_err : 1'b0);
      chk("rsp_timeout", bus.rsp_timeout, ev ? e_to : 1'b0);
    end
    if (acc_count != prev_acc) begin
      prev_acc = acc_count;
      m_psel   = 0;
      m_pen    = 0;
      m_rv     = 0;
      m_rv_k   = 0;
    end
    if (bus.psel === 1'b1) begin
      m_psel++;
      cap_pwdata = bus.pwdata;
    end
    if (bus.penable === 1'b1) m_pen++;
    if (bus.rsp_valid === 1'b1) begin
      if (m_rv == 0) m_rv_k = k;
      m_rv++;
      cap_rdata = bus.rsp_rdata;
      cap_err   = bus.rsp_err;
      cap_to    = bus.rsp_timeout;
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge pclk);
    #2 preset = 1'b0;
    @(negedge pclk);

    add(1'b1, 32'd5, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0);
    wait_idle(100);
    chk("t1_psel_cycles", m_psel, 2);
    chk("t1_penable_cycles", m_pen, 1);
    chk("t1_rsp_latency", m_rv_k, 3);
    chk("t1_pwdata", cap_pwdata, 32'hDEADBEEF);
    chk("t1_rdata", cap_rdata, 32'h0);
    chk("t1_err", cap_err, 1'b0);

    add(1'b0, 32'd5, 32'h0, 3, 1'b0, 32'hDEADBEEF, 0);
    wait_idle(100);
    chk("t2_access_cycles", m_pen, 4);
    chk("t2_rsp_latency", m_rv_k, 6);
    chk("t2_rdata", cap_rdata, 32'hDEADBEEF);
    chk("t2_err", cap_err, 1'b0);

    add(1'b0, 32'd40, 32'h0, 0, 1'b1, 32'h1234, 1);
    wait_idle(100);
    chk("t3_err", cap_err, 1'b1);
    chk("t3_rdata", cap_rdata, 32'h0);
    chk("t3_timeout", cap_to, 1'b0);

`ifdef APB_REQUESTER_TIMEOUT_EN
    add(1'b0, 32'd8, 32'h0, 20, 1'b0, 32'hCAFE, 0);
    wait_idle(100);
    chk("t4_access_cycles", m_pen, 4);
    chk("t4_err", cap_err, 1'b1);
    chk("t4_timeout", cap_to, 1'b1);
    chk("t4_rdata", cap_rdata, 32'h0);

    add(1'b0, 32'd8, 32'h0, 3, 1'b0, 32'hCAFE, 0);
    wait_idle(100);
    chk("t5_access_cycles", m_pen, 4);
    chk("t5_timeout", cap_to, 1'b0);
    chk("t5_rdata", cap_rdata, 32'hCAFE);
`endif

    add(1'b1, 32'd12, 32'h11, 1, 1'b0, 32'h0, 3);
    add(1'b0, 32'd12, 32'h0, 0, 1'b0, 32'h22, 3);
    wait_idle(200);
    chk("t6_accept_gap", gap, 1);
    chk("t6_rsp_hold_cycles", m_rv, 4);
    chk("t6_rdata", cap_rdata, 32'h22);

    add(1'b0, 32'd16, 32'h0, 50, 1'b0, 32'h0, 0);
    n = 0;
    while (!(busy && (cyc + 1 - t_acc) == 3)) begin
      @(negedge pclk);
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL t7_reach_access: ACCESS not reached within 50 cycles");
        finish_tb();
      end
    end
    #2 preset = 1'b1;
    #1;
    chk("t7_psel_async", bus.psel, 1'b0);
    chk("t7_penable_async", bus.penable, 1'b0);
    chk("t7_rsp_valid_async", bus.rsp_valid, 1'b0);
    chk("t7_cmd_ready_in_reset", bus.cmd_ready, 1'b0);
    repeat (2) @(negedge pclk);
    #2 preset = 1'b0;
    @(negedge pclk);
    #1;
    chk("t7_cmd_ready_after", bus.cmd_ready, 1'b1);
    chk("t7_no_rsp", bus.rsp_valid, 1'b0);

    rand_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      add(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 6),
          $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3));
    end
    wait_idle(4000);
    finish_tb();
  end

endmodule

`default_nettype wire
